// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM encoding, BCD digit limits
// and the load-value clamp.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int             BCD_W   = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    // Out-of-range BCD digits saturate to 9 rather than being rejected.
    function automatic logic [2*BCD_W-1:0] clamp_bcd(input logic [2*BCD_W-1:0] v);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        tens = (v[2*BCD_W-1:BCD_W] > BCD_MAX) ? BCD_MAX : v[2*BCD_W-1:BCD_W];
        ones = (v[BCD_W-1:0] > BCD_MAX) ? BCD_MAX : v[BCD_W-1:0];
        return {tens, ones};
    endfunction

endpackage

// File: rtl/bcd_dec_digit.sv
// One BCD digit of the down-counter: decrements when enabled, wrapping 0 -> 9
// and raising borrow so the next-higher digit can be enabled.
module bcd_dec_digit
    import countdown_timer_pkg::*;
(
    input  logic [BCD_W-1:0] val,
    input  logic             en,
    output logic [BCD_W-1:0] next,
    output logic             borrow
);

    always_comb begin
        next   = val;
        borrow = 1'b0;
        if (en) begin
            if (val == '0) begin
                next   = BCD_MAX;
                borrow = 1'b1;
            end else begin
                next = val - 1'b1;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown with an internal prescaler; one decrement per
// TICK_DIV clocks while running, single-cycle expired pulse on reaching 00.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int TICK_W   = 27
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       start,
    input  logic       stop,
    output logic [7:0] time_reading,
    output logic       running,
    output logic       expired
);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [7:0]        READ_ONE  = 8'h01;

    state_t            state;
    state_t            state_nxt;
    logic [TICK_W-1:0] prescaler;
    logic              tick;
    logic              reading_zero;
    logic [BCD_W-1:0]  ones_nxt;
    logic [BCD_W-1:0]  tens_nxt;
    logic              ones_borrow;
    logic              tens_borrow;
    logic              dec_ok;

    assign reading_zero = (time_reading == 8'h00);
    assign tick         = (state == ST_RUN) && (prescaler == TICK_LAST);
    // A borrow out of the tens digit would mean wrapping below 00; never commit it.
    assign dec_ok       = tick && !tens_borrow;

    bcd_dec_digit u_ones (
        .val    (time_reading[BCD_W-1:0]),
        .en     (tick),
        .next   (ones_nxt),
        .borrow (ones_borrow)
    );

    bcd_dec_digit u_tens (
        .val    (time_reading[2*BCD_W-1:BCD_W]),
        .en     (ones_borrow),
        .next   (tens_nxt),
        .borrow (tens_borrow)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // load overrides everything; stop outranks start in the same cycle.
    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start && !stop && !reading_zero) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (dec_ok && (time_reading == READ_ONE)) state_nxt = ST_DONE;
                    else if (stop)                             state_nxt = ST_PAUSE;
                end
                ST_PAUSE: if (start && !stop) state_nxt = ST_RUN;
                ST_DONE:  state_nxt = ST_DONE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == ST_RUN);
    end

    // The prescaler keeps its value across PAUSE so a resumed count finishes
    // the partial second instead of restarting it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            time_reading <= 8'h00;
            prescaler    <= '0;
            expired      <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                time_reading <= clamp_bcd(load_value);
                prescaler    <= '0;
            end else if (state == ST_RUN) begin
                if (tick) begin
                    prescaler <= '0;
                    if (dec_ok) begin
                        time_reading <= {tens_nxt, ones_nxt};
                        expired      <= (time_reading == READ_ONE);
                    end
                end else begin
                    prescaler <= prescaler + TICK_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios with literal expectations plus
// random strobes, all compared every cycle against a seconds-based model.
module tb_countdown_timer;

    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'h00;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] time_reading;
    logic       running;
    logic       expired;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    // Model: remaining seconds as an integer, phase = clocks into current second.
    int m_secs   = 0;
    int m_phase  = 0;
    bit m_run    = 1'b0;
    bit m_paused = 1'b0;
    bit m_fin    = 1'b0;
    bit m_exp    = 1'b0;

    always #5 clk = ~clk;

    countdown_timer #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .load         (load),
        .load_value   (load_value),
        .start        (start),
        .stop         (stop),
        .time_reading (time_reading),
        .running      (running),
        .expired      (expired)
    );

    function automatic logic [7:0] to_bcd(input int s);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(s / 10);
        o = 4'(s % 10);
        return {t, o};
    endfunction

    function automatic int clamp_secs(input logic [7:0] v);
        int t;
        int o;
        t = int'(v[7:4]);
        o = int'(v[3:0]);
        if (t > 9) t = 9;
        if (o > 9) o = 9;
        return t * 10 + o;
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_secs = 0; m_phase = 0; m_run = 0; m_paused = 0; m_fin = 0; m_exp = 0;
        end else begin
            m_exp = 0;
            if (load) begin
                m_secs = clamp_secs(load_value);
                m_phase = 0; m_run = 0; m_paused = 0; m_fin = 0;
            end else if (m_run) begin
                m_phase++;
                if (m_phase == TICK_DIV) begin
                    m_phase = 0;
                    m_secs--;
                    if (m_secs == 0) begin
                        m_exp = 1; m_run = 0; m_fin = 1;
                    end
                end
                if (m_run && stop) begin
                    m_run = 0; m_paused = 1;
                end
            end else if (start && !stop && (m_paused || (!m_fin && m_secs != 0))) begin
                m_run = 1; m_paused = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_reading", time_reading, to_bcd(m_secs));
            chk("model_running", {7'b0, running}, {7'b0, m_run});
            chk("model_expired", {7'b0, expired}, {7'b0, m_exp});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_value = v; cyc(1); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; cyc(1); stop = 1'b0;
    endtask

    initial begin
        cyc(2);
        chk("rst_reading", time_reading, 8'h00);
        chk("rst_running", {7'b0, running}, 8'h00);
        chk("rst_expired", {7'b0, expired}, 8'h00);
        rstn = 1'b1;
        cmp_en = 1'b1;
        cyc(1);

        // 12 seconds down to expiry
        do_load(8'h12);
        do_start();
        chk("run_rise", {7'b0, running}, 8'h01);
        cyc(4);  chk("cd_11", time_reading, 8'h11);
        cyc(4);  chk("cd_10", time_reading, 8'h10);
        cyc(4);  chk("cd_09_borrow", time_reading, 8'h09);
        cyc(32); chk("cd_01", time_reading, 8'h01);
        chk("cd_no_early_exp", {7'b0, expired}, 8'h00);
        cyc(4);  chk("cd_00", time_reading, 8'h00);
        chk("exp_pulse", {7'b0, expired}, 8'h01);
        chk("done_not_running", {7'b0, running}, 8'h00);
        cyc(1);  chk("exp_single", {7'b0, expired}, 8'h00);
        do_start();
        cyc(1);
        chk("done_start_ignored", {7'b0, running}, 8'h00);
        chk("done_hold_00", time_reading, 8'h00);

        // pause retains prescaler
        do_load(8'h05);
        do_start();
        cyc(5);
        do_stop();
        chk("pause_reading", time_reading, 8'h04);
        chk("pause_running", {7'b0, running}, 8'h00);
        cyc(3);
        chk("pause_frozen", time_reading, 8'h04);
        do_start();
        chk("resume_running", {7'b0, running}, 8'h01);
        cyc(1);  chk("resume_mid", time_reading, 8'h04);
        cyc(1);  chk("resume_dec", time_reading, 8'h03);

        // load wins over start in the same cycle
        load = 1'b1; start = 1'b1; load_value = 8'h30;
        cyc(1);
        load = 1'b0; start = 1'b0;
        chk("ld_st_reading", time_reading, 8'h30);
        chk("ld_st_idle", {7'b0, running}, 8'h00);
        cyc(8);
        chk("ld_st_no_count", time_reading, 8'h30);

        do_load(8'hAB);
        chk("clamp_AB", time_reading, 8'h99);
        do_load(8'hA5);
        chk("clamp_A5", time_reading, 8'h95);
        do_load(8'h00);
        do_start();
        cyc(5);
        chk("zero_no_run", {7'b0, running}, 8'h00);
        chk("zero_no_exp", {7'b0, expired}, 8'h00);

        // reload during RUN resets prescaler
        do_load(8'h08);
        do_start();
        cyc(4);
        chk("rl_07", time_reading, 8'h07);
        cyc(2);
        do_load(8'h20);
        chk("rl_20", time_reading, 8'h20);
        chk("rl_idle", {7'b0, running}, 8'h00);
        do_start();
        cyc(3);  chk("rl_hold", time_reading, 8'h20);
        cyc(1);  chk("rl_19", time_reading, 8'h19);

        // asynchronous reset mid-count
        do_load(8'h15);
        do_start();
        cyc(5);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_reading", time_reading, 8'h00);
        chk("arst_running", {7'b0, running}, 8'h00);
        chk("arst_expired", {7'b0, expired}, 8'h00);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(1);

        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(99) < 3);
            if ($urandom_range(1) == 1) load_value = 8'($urandom_range(255));
            else                        load_value = {4'h0, 4'($urandom_range(15))};
            start = ($urandom_range(99) < 12);
            stop  = ($urandom_range(99) < 4);
            cyc(1);
        end
        load = 1'b0; start = 1'b0; stop = 1'b0;
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
